// File: rtl/div_sequencer.sv
// div_sequencer: multicycle signed integer divide controller.
// Restoring shift/subtract datapath producing one quotient bit per cycle,
// with invert-plus-one sign correction of operands and results.
// Optional feature macro DIV_REMAINDER_EN adds the data_remainder port
// (remainder sign follows the dividend).

module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PREP  = 3'd1;
  localparam logic [2:0] ITER  = 3'd2;
  localparam logic [2:0] FIXUP = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    ONE_C      = CW'(1);
  localparam logic [WIDTH-1:0] ONE_W      = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_X      = (WIDTH + 1)'(1);
  localparam logic [WIDTH+1:0] ONE_T      = (WIDTH + 2)'(1);
  localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH - 1){1'b0}}};

  logic [2:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   abs_b;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic             qsign;
  logic             exc;
`ifdef DIV_REMAINDER_EN
  logic             rsign;
`endif

  // The remainder register carries one extra bit so a divisor magnitude of
  // 2^(WIDTH-1) and the shifted partial remainder never overflow; the trial
  // difference carries one more bit again so its sign is always exact.
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   b_mag;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_neg;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             overflow_case;

  // Operand magnitudes and one restoring-division step
  always_comb begin
    abs_a         = op_a[WIDTH-1] ? (~op_a + ONE_W) : op_a;
    b_ext         = {op_b[WIDTH-1], op_b};
    b_mag         = op_b[WIDTH-1] ? (~b_ext + ONE_X) : b_ext;
    shifted       = {rem, quo[WIDTH-1]};
    trial         = shifted + ~{1'b0, abs_b} + ONE_T;
    trial_neg     = trial[WIDTH+1];
    rem_next      = trial_neg ? shifted[WIDTH:0] : trial[WIDTH:0];
    quo_next      = {quo[WIDTH-2:0], ~trial_neg};
    overflow_case = (op_a == MOST_NEG) && (op_b == '1);
  end

  // Control sequencing and datapath registers; a start pulse always wins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      op_a  <= '0;
      op_b  <= '0;
      abs_b <= '0;
      rem   <= '0;
      quo   <= '0;
      qsign <= 1'b0;
      exc   <= 1'b0;
`ifdef DIV_REMAINDER_EN
      rsign <= 1'b0;
`endif
    end else if (ctrl_DIV) begin
      op_a  <= data_operandA;
      op_b  <= data_operandB;
      count <= '0;
      state <= PREP;
    end else begin
      case (state)
        IDLE: state <= IDLE;
        PREP: begin
          count <= '0;
          rem   <= '0;
          if (op_b == '0) begin
            exc   <= 1'b1;
            quo   <= '0;
            state <= DONE;
          end else if (overflow_case) begin
            exc   <= 1'b1;
            quo   <= MOST_NEG;
            state <= DONE;
          end else begin
            exc   <= 1'b0;
            abs_b <= b_mag;
            quo   <= abs_a;
            qsign <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
`ifdef DIV_REMAINDER_EN
            rsign <= op_a[WIDTH-1];
`endif
            state <= ITER;
          end
        end
        ITER: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + ONE_C;
          if (count == LAST_COUNT) state <= FIXUP;
        end
        FIXUP: begin
          if (qsign) quo <= ~quo + ONE_W;
`ifdef DIV_REMAINDER_EN
          if (rsign) rem <= ~rem + ONE_X;
`endif
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Registered status/result outputs, one cycle behind the state they report
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
`ifdef DIV_REMAINDER_EN
      data_remainder <= '0;
`endif
    end else begin
      data_resultRDY <= (state == DONE);
      busy           <= (state == PREP) || (state == ITER) || (state == FIXUP);
      if (state == DONE) begin
        data_result    <= quo;
        data_exception <= exc;
`ifdef DIV_REMAINDER_EN
        data_remainder <= rem[WIDTH-1:0];
`endif
      end
    end
  end

endmodule
